// File: rtl/div_const_pkg.sv
// Constants and shared types for the divide-by-113 controller and its digit-step table.
package div_const_pkg;

  localparam int N_BITS  = 60;
  localparam int DIGIT_W = 4;
  localparam int DIVISOR = 113;
  localparam int REM_W   = 7;
  localparam int NSTEP   = N_BITS / DIGIT_W;
  localparam int CNT_W   = 4;
  localparam int STEP_W  = REM_W + DIGIT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] qd;
    logic [REM_W-1:0]   nr;
  } step_res_t;

endpackage

// File: rtl/div113_digit_step.sv
// One radix-2^DIGIT_W long-division step by the constant divisor, built from
// constant-threshold compares so it maps to table logic rather than a divider.
module div113_digit_step
  import div_const_pkg::*;
(
  input  logic [REM_W-1:0]   r_i,
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] qd_o,
  output logic [REM_W-1:0]   nr_o
);

  logic [STEP_W-1:0] v;
  logic [STEP_W-1:0] sub;
  step_res_t         res;

  assign v = {r_i, d_i};

  // r_i < DIVISOR keeps v below DIVISOR*2^DIGIT_W, so the largest matching multiple is the digit.
  always_comb begin
    res = '0;
    sub = '0;
    for (int k = 1; k < (1 << DIGIT_W); k++) begin
      if (int'(v) >= k * DIVISOR) begin
        res.qd = DIGIT_W'(k);
        sub    = STEP_W'(k * DIVISOR);
      end
    end
    res.nr = REM_W'(v - sub);
  end

  assign qd_o = res.qd;
  assign nr_o = res.nr;

endmodule

// File: rtl/div113_seq_ctrl.sv
// Sequential divide-by-113: MSB-first digit recurrence with valid/ready on both sides.
module div113_seq_ctrl
  import div_const_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_quot,
  output logic [REM_W-1:0]  out_rem,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]         state_q, state_d;
  logic [N_BITS-1:0]  w_q, w_d;
  logic [REM_W-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_BITS-1:0]  quot_q, quot_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [DIGIT_W-1:0] step_qd;
  logic [REM_W-1:0]   step_nr;
  logic [N_BITS-1:0]  w_shift;

  div113_digit_step u_step (
    .r_i  (r_q),
    .d_i  (w_q[N_BITS-1 -: DIGIT_W]),
    .qd_o (step_qd),
    .nr_o (step_nr)
  );

  assign w_shift = {w_q[N_BITS-DIGIT_W-1:0], step_qd};

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          w_d     = in_data;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        w_d   = w_shift;
        r_d   = step_nr;
        cnt_d = cnt_q + 1'b1;
        // Result registers are separate from W so outputs hold steady outside DONE.
        if (cnt_q == CNT_W'(NSTEP - 1)) begin
          quot_d  = w_shift;
          rem_d   = step_nr;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_quot  = quot_q;
  assign out_rem   = rem_q;

endmodule

// File: tb/tb_div113_seq_ctrl.sv
// Self-checking bench: directed cases plus randomized traffic against x/113, x%113.
module tb_div113_seq_ctrl;

  localparam int NB = 60;
  localparam int N_RAND = 1500;
  localparam logic [63:0] DIV = 64'd113;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_quot;
  logic [6:0]    out_rem;
  logic          busy;

  int n_assert;
  int n_fail;

  div113_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_rem   (out_rem),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer x, check acceptance, latency and result, then consume the result.
  task automatic run_op(input string tag, input logic [NB-1:0] x,
                        input logic [63:0] eq, input logic [63:0] er);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin cyc(); lat++; end
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_data  = '1;
    chk({tag, "_accepted"}, {62'd0, busy, in_ready}, 64'd2);
    lat = 0;
    while (!out_valid && lat < 40) begin cyc(); lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'd15);
    chk({tag, "_quot"}, {4'd0, out_quot}, eq);
    chk({tag, "_rem"}, {57'd0, out_rem}, er);
    cyc();
    chk({tag, "_released"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] exp_r[$];
  logic [63:0] x64, hq, hr;
  logic [NB-1:0] held_quot;
  logic [6:0]    held_rem;
  logic          hold_chk;
  int            n_got, n_sent, cycles;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_quot", {4'd0, out_quot}, 64'd0);
    chk("reset_rem", {57'd0, out_rem}, 64'd0);

    run_op("d1000", 60'd1000, 64'd8, 64'd96);
    run_op("d0", 60'd0, 64'd0, 64'd0);
    run_op("d113", 60'd113, 64'd1, 64'd0);
    run_op("d112", 60'd112, 64'd0, 64'd112);
    run_op("dmax", 60'hFFF_FFFF_FFFF_FFFF, 64'd10202845173511920, 64'd15);

    // Back-pressure with a second dividend already waiting.
    in_valid  = 1'b1;
    in_data   = 60'd5000;
    out_ready = 1'b0;
    cyc();
    in_data = 60'd777;
    cycles = 0;
    while (!out_valid && cycles < 40) begin cyc(); cycles++; end
    chk("bp_latency", 64'(cycles), 64'd15);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_quot", {4'd0, out_quot}, 64'd44);
      chk("bp_rem", {57'd0, out_rem}, 64'd28);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_handshake", {62'd0, out_valid, in_ready}, 64'd1);
    chk("bp_quot_hold", {4'd0, out_quot}, 64'd44);
    cyc();
    chk("bp_second_accept", {62'd0, busy, in_ready}, 64'd2);
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 40) begin cyc(); cycles++; end
    chk("bp2_latency", 64'(cycles), 64'd15);
    chk("bp2_quot", {4'd0, out_quot}, 64'd6);
    chk("bp2_rem", {57'd0, out_rem}, 64'd99);
    cyc();

    // Abort in the 7th RUN cycle.
    in_valid = 1'b1;
    in_data  = 60'd123456;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("abort_running", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_idle", {62'd0, busy, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_quot", {4'd0, out_quot}, 64'd0);
    chk("abort_rem", {57'd0, out_rem}, 64'd0);
    run_op("d226", 60'd226, 64'd2, 64'd0);

    // Randomized traffic: the producer holds each offer until it is taken.
    n_got    = 0;
    n_sent   = 0;
    cycles   = 0;
    in_valid = 1'b0;
    hold_chk = 1'b0;
    while (n_got < N_RAND && cycles < 60000) begin
      if (hold_chk) begin
        chk("rand_hold_quot", {4'd0, out_quot}, {4'd0, held_quot});
        chk("rand_hold_rem", {57'd0, out_rem}, {57'd0, held_rem});
      end
      if (!in_valid && n_sent < N_RAND && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 9))
          0:       in_data = '0;
          1:       in_data = '1;
          2:       in_data = 60'($urandom_range(0, 300));
          default: in_data = {$urandom, $urandom};
        endcase
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        x64 = {4'd0, in_data};
        exp_q.push_back(x64 / DIV);
        exp_r.push_back(x64 % DIV);
        n_sent++;
      end
      hold_chk = out_valid && !out_ready;
      held_quot = out_quot;
      held_rem  = out_rem;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_result", 64'd1, 64'd0);
        end else begin
          hq = exp_q.pop_front();
          hr = exp_r.pop_front();
          chk("rand_quot", {4'd0, out_quot}, hq);
          chk("rand_rem", {57'd0, out_rem}, hr);
          chk("rand_rem_range", {63'd0, (out_rem < 7'd113)}, 64'd1);
        end
        n_got++;
      end
      cyc();
      if (in_valid && !busy) begin
      end else if (in_valid && busy && !in_ready) begin
        in_valid = 1'b0;
      end
      cycles++;
    end
    chk("rand_count", 64'(n_got), 64'(N_RAND));
    chk("rand_sent", 64'(n_sent), 64'(N_RAND));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
